// File: rtl/crc5_rx_check.sv
// Serial CRC-5 (x^5+x^2+1) frame checker: 8 data bits then 5 CRC bits, MSB first.
// Latency: done/results are registered on the edge that samples the 13th bit.
// Backpressure: none; rx_en=0 cycles stall reception with no state change.
module crc5_rx_check (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_bit,
    input  logic       rx_en,
    input  logic       sof,
    output logic [7:0] data_out,
    output logic [4:0] crc_rx,
    output logic       done,
    output logic       crc_ok,
    output logic       crc_err,
    output logic       busy,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;

    function automatic logic [4:0] crc_step(input logic [4:0] c, input logic b);
        logic fb;
        fb = c[4] ^ b;
        return {c[3], c[2], c[1] ^ fb, c[0], fb};
    endfunction

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] data_sh;
    logic [4:0] crc_calc;
    logic [3:0] crc_sh;
    logic [4:0] crc_last;
    logic       crc_match;

    // Received CRC including the bit being sampled this cycle.
    assign crc_last  = {crc_sh, rx_bit};
    assign crc_match = (crc_calc == crc_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            data_sh  <= 8'h00;
            crc_calc <= 5'h00;
            crc_sh   <= 4'h0;
            data_out <= 8'h00;
            crc_rx   <= 5'h00;
            done     <= 1'b0;
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
            busy     <= 1'b0;
            err_cnt  <= 8'h00;
        end else begin
            done <= 1'b0;
            if (rx_en) begin
                if (sof) begin
                    // sof always (re)starts a frame, aborting any partial one.
                    state    <= DATA;
                    bit_cnt  <= 4'd1;
                    data_sh  <= {7'b0, rx_bit};
                    crc_calc <= crc_step(5'h00, rx_bit);
                    crc_sh   <= 4'h0;
                    busy     <= 1'b1;
                end else begin
                    case (state)
                        DATA: begin
                            data_sh  <= {data_sh[6:0], rx_bit};
                            crc_calc <= crc_step(crc_calc, rx_bit);
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7)
                                state <= CRC;
                        end
                        CRC: begin
                            crc_sh  <= crc_last[3:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd12) begin
                                state    <= IDLE;
                                bit_cnt  <= 4'd0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                data_out <= data_sh;
                                crc_rx   <= crc_last;
                                crc_ok   <= crc_match;
                                crc_err  <= !crc_match;
                                if (!crc_match && err_cnt != 8'hFF)
                                    err_cnt <= err_cnt + 8'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_crc5_rx_check.sv
// Bench for crc5_rx_check: table-driven frames plus hand-written corner sequences, scoreboard-checked.
module tb_crc5_rx_check;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_bit = 1'b0;
    logic       rx_en = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] data_out;
    logic [4:0] crc_rx;
    logic       done;
    logic       crc_ok;
    logic       crc_err;
    logic       busy;
    logic [7:0] err_cnt;

    crc5_rx_check dut (
        .clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_en(rx_en), .sof(sof),
        .data_out(data_out), .crc_rx(crc_rx), .done(done), .crc_ok(crc_ok),
        .crc_err(crc_err), .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [4:0] crc;
        logic       ok;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic [4:0] crc;
        bit         gaps;
    } vec_t;

    exp_t sb[$];
    int   done_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    bit   prev_done = 1'b0;
    logic [7:0] model_err = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference CRC written as polynomial long division.
    function automatic logic [4:0] model_crc(input logic [7:0] d);
        logic [4:0] c;
        c = 5'h00;
        for (int i = 7; i >= 0; i--) begin
            if (c[4] ^ d[i]) c = {c[3:0], 1'b0} ^ 5'h05;
            else             c = {c[3:0], 1'b0};
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            chk("done_width", {31'b0, prev_done}, 32'd0);
            done_cnt++;
            done_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("data_out", {24'b0, data_out}, {24'b0, e.data});
                chk("crc_rx", {27'b0, crc_rx}, {27'b0, e.crc});
                chk("crc_ok", {31'b0, crc_ok}, {31'b0, e.ok});
                chk("crc_err", {31'b0, crc_err}, {31'b0, !e.ok});
                chk("err_cnt", {24'b0, err_cnt}, {24'b0, e.cnt});
            end
        end
        prev_done = done;
    end

    task automatic send_bit(input logic b, input logic s, input bit gaps);
        int n;
        if (gaps) begin
            n = $urandom_range(0, 3);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        end
        rx_bit = b;
        sof    = s;
        rx_en  = 1'b1;
        @(posedge clk);
        #1;
        rx_en = 1'b0;
        sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [4:0] c, input bit gaps);
        exp_t e;
        for (int i = 7; i >= 0; i--) send_bit(d[i], (i == 7), gaps);
        for (int i = 4; i >= 0; i--) begin
            if (i == 0) begin
                e.data = d;
                e.crc  = c;
                e.ok   = (model_crc(d) == c);
                if (!e.ok && model_err != 8'hFF) model_err = model_err + 8'd1;
                e.cnt  = model_err;
                sb.push_back(e);
            end
            send_bit(c[i], 1'b0, gaps);
        end
        chk("latency_done", {31'b0, done}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_data_out"}, {24'b0, data_out}, 32'd0);
        chk({tag, "_crc_rx"}, {27'b0, crc_rx}, 32'd0);
        chk({tag, "_crc_ok"}, {31'b0, crc_ok}, 32'd0);
        chk({tag, "_crc_err"}, {31'b0, crc_err}, 32'd0);
        chk({tag, "_err_cnt"}, {24'b0, err_cnt}, 32'd0);
    endtask

    initial begin
        vec_t vecs[5];
        int   d0;
        int   n;
        vecs[0] = '{8'h01, 5'h05, 1'b0};
        vecs[1] = '{8'h80, 5'h0E, 1'b1};
        vecs[2] = '{8'h80, 5'h0F, 1'b0};
        vecs[3] = '{8'h3C, model_crc(8'h3C), 1'b1};
        vecs[4] = '{8'hFF, model_crc(8'hFF) ^ 5'h01, 1'b0};

        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Bits without sof in IDLE are ignored.
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
        chk("idle_ignore_busy", {31'b0, busy}, 32'd0);

        // Known vectors: 0x01/0x05 and 0x80/0x0E are good, 0x80/0x0F is bad.
        chk("model_01", {27'b0, model_crc(vecs[0].data)}, 32'h05);
        chk("model_80", {27'b0, model_crc(vecs[1].data)}, 32'h0E);

        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            send_frame(vecs[i].data, vecs[i].crc, vecs[i].gaps);
            @(negedge clk);
            #1;
            chk("single_done", done_cnt - d0, 32'd1);
        end

        // Bad frame then idle: error flags and outputs held until next done.
        send_frame(8'h80, 5'h0F, 1'b0);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("hold_crc_err", {31'b0, crc_err}, 32'd1);
        chk("hold_crc_ok", {31'b0, crc_ok}, 32'd0);
        chk("hold_data_out", {24'b0, data_out}, 32'h80);
        chk("hold_err_cnt", {24'b0, err_cnt}, {24'b0, model_err});

        // Abort after 6 bits, then full 0x00/0x00 frame.
        d0 = done_cnt;
        send_bit(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
        chk("abort_busy", {31'b0, busy}, 32'd1);
        send_frame(8'h00, 5'h00, 1'b0);
        @(negedge clk);
        #1;
        chk("abort_one_done", done_cnt - d0, 32'd1);

        // Back-to-back: second sof lands in the first frame's done cycle.
        d0 = done_cnt;
        send_frame(8'h5A, model_crc(8'h5A), 1'b0);
        send_frame(8'hC3, model_crc(8'hC3) ^ 5'h10, 1'b0);
        @(negedge clk);
        #1;
        chk("b2b_two_done", done_cnt - d0, 32'd2);
        n = done_cyc.size();
        if (n >= 2) chk("b2b_spacing", done_cyc[n-1] - done_cyc[n-2], 32'd13);
        else        chk("b2b_spacing_missing", n, 32'd2);

        // Reset mid-frame: outputs return to reset values immediately.
        send_bit(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_err = 8'h00;
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        d0 = done_cnt;
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0, 1'b0);
        chk("post_rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        #1;
        chk("post_rst_no_done", done_cnt - d0, 32'd0);

        // 256 bad frames: err_cnt saturates.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] d;
            d = i[7:0];
            send_frame(d, model_crc(d) ^ 5'h01, 1'b0);
        end
        @(negedge clk);
        #1;
        chk("err_cnt_sat", {24'b0, err_cnt}, 32'hFF);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
